instr_byte_feeder: RTL and testbench
====================================

// Module: instr_byte_feeder
//
// PURPOSE
// - Supply side of the core's 32-bit instruction port. Accepts instruction bytes from the 8-bit pad
//   input (ui_in) and assembles them little-endian into 32-bit words.
// - Buffers complete words in a small FIFO and presents the head word to single_cycle_datapath
//   through a valid/ready handshake.
// - Sits between the tt_um top wrapper and the core; the core advances its pc only on a pop.
//
// PARAMETERS
// - DEPTH           4    FIFO entries, power of 2, >= 2
// - TIMEOUT_CYCLES  255  idle cycles before a partial word is dropped (only with PARTIAL_WORD_TIMEOUT_EN)
//
// PORTS
// - clk          in   1                 clock
// - rst          in   1                 reset
// - flush        in   1                 synchronous clear of assembler and FIFO
// - byte_in      in   8                 instruction byte
// - byte_valid   in   1                 byte_in is valid
// - byte_ready   out  1                 feeder accepts byte_in this cycle
// - instr        out  32                FIFO head word
// - instr_valid  out  1                 instr holds a complete word
// - instr_ready  in   1                 core consumes instr this cycle
// - level        out  $clog2(DEPTH)+1   number of words in the FIFO
// - byte_idx     out  2                 next byte lane to fill (0..3)
// - timeout_err  out  1                 one-cycle pulse when a partial word is dropped
//
// BEHAVIOUR
// Interface
// - Reset rst is synchronous and active-high; clock is clk. All state updates on posedge clk.
// - Reset values: byte_ready=0 while rst is high, instr_valid=0, instr=0 (all entries cleared),
//   level=0, byte_idx=0, timeout_err=0.
//
// Handshakes
// - A byte is accepted when byte_valid & byte_ready.
// - A word is popped when instr_valid & instr_ready.
//
// Assembler
// - An accepted byte is written to lane byte_idx, bits [8*byte_idx+7 : 8*byte_idx].
// - byte_idx increments by 1 and wraps 3 -> 0.
// - When the lane-3 byte is accepted, the complete word (including that byte) is pushed into the FIFO
//   at the same edge.
//
// byte_ready
// - byte_ready = !rst & !flush & (byte_idx != 3 | level != DEPTH).
// - byte_ready is derived from registered state only; there is no path from instr_ready to byte_ready.
//   A full FIFO therefore frees a slot for a new word one cycle after the pop.
//
// FIFO and latency
// - instr_valid = (level != 0). instr is the head entry and stays stable while instr_valid & !instr_ready.
// - Latency: lane-3 byte accepted at edge N into an empty FIFO -> instr_valid=1 and the word on instr
//   from edge N onward (1 cycle).
// - Simultaneous push and pop: level is unchanged, ordering is preserved, and the popped word is the old head.
// - Pointers are $clog2(DEPTH) bits and wrap naturally. level is the exact count.
//
// flush
// - Priority over push and pop. At the edge: level=0, byte_idx=0, partial word discarded, no byte accepted.
//
// Reset mid-operation
// - rst behaves like flush and also zeroes all entries and timeout_err.
//
// CONFIGURATION
// - PARTIAL_WORD_TIMEOUT_EN defined:
//   - An idle counter clears on every accepted byte and counts while byte_idx != 0.
//   - When the counter reaches TIMEOUT_CYCLES: byte_idx=0, partial word dropped, timeout_err=1 for 1 cycle.
//   - A byte accepted in the same cycle as the timeout wins: no drop, no pulse.
//   - flush and rst clear the counter.
// - PARTIAL_WORD_TIMEOUT_EN undefined:
//   - No counter. A partial word is held indefinitely. timeout_err is tied to 0.
//
// TESTING
// - Basic word: after reset, send bytes 13,05,A0,00 with instr_ready=0
//   -> instr=32'h00A00513, instr_valid=1, level=1, byte_idx=0.
// - Fill: send DEPTH words with instr_ready=0, then byte_idx=3
//   -> byte_ready=0 on lane 3. After one pop, byte_ready=1 on the next cycle; word order is preserved.
// - Concurrent traffic: level=2, lane-3 byte accepted while popping
//   -> level stays 2; popped word is the old head.
// - Flush mid-word: byte_idx=2, flush=1 with byte_valid=1
//   -> byte not taken, byte_idx=0, level=0, instr_valid=0.
// - Mid-operation reset: rst=1 with level=3, byte_idx=1
//   -> next cycle level=0, instr=0, byte_ready=0. First byte after release goes to lane 0.
// - Timeout, macro on, TIMEOUT_CYCLES=8: send one byte, then idle 8 cycles
//   -> timeout_err pulses once, byte_idx=0, level unchanged. With the macro off: byte_idx stays 1.

Source files
------------

// File: rtl/instr_byte_feeder_if.sv
// Byte-in / word-out handshake bundle for instr_byte_feeder.
// master drives bytes and consumes words; slave is the feeder itself.
interface instr_byte_feeder_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output byte_in, byte_valid, instr_ready,
    input  byte_ready, instr, instr_valid
  );

  modport slave (
    input  byte_in, byte_valid, instr_ready,
    output byte_ready, instr, instr_valid
  );
endinterface

// File: rtl/instr_byte_feeder.sv
// Assembles little-endian instruction bytes into 32-bit words and queues them for the core.
// Optional partial-word idle timeout is enabled by defining PARTIAL_WORD_TIMEOUT_EN.
module instr_byte_feeder #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  instr_byte_feeder_if.slave       bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic [1:0]               byte_idx,
  output logic                     timeout_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [23:0]   asm_q, asm_d;
  logic          timeout_err_q, timeout_err_d;

  logic byte_ready;
  logic instr_valid;
  logic byte_acc;
  logic push;
  logic pop;
  logic timeout_hit;

  // byte_ready looks only at registered state, so a pop frees a full slot one cycle later
  assign byte_ready  = !rst && !flush && (byte_idx_q != 2'd3 || level_q != FULL);
  assign instr_valid = (level_q != '0);
  assign byte_acc    = bus.byte_valid && byte_ready;
  assign push        = byte_acc && (byte_idx_q == 2'd3);
  assign pop         = instr_valid && bus.instr_ready;

  assign bus.byte_ready  = byte_ready;
  assign bus.instr_valid = instr_valid;
  assign bus.instr       = mem_q[rd_ptr_q];
  assign level           = level_q;
  assign byte_idx        = byte_idx_q;
  assign timeout_err     = timeout_err_q;

`ifdef PARTIAL_WORD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW:0] TLIM = (CW+1)'(TIMEOUT_CYCLES);

  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic [CW:0]   cnt_inc;

  assign cnt_inc     = {1'b0, idle_cnt_q} + 1'b1;
  assign timeout_hit = !byte_acc && (byte_idx_q != 2'd0) && (cnt_inc == TLIM);

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (rst || flush || byte_acc || byte_idx_q == 2'd0 || timeout_hit) begin
      idle_cnt_d = '0;
    end else begin
      idle_cnt_d = cnt_inc[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    idle_cnt_q <= idle_cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    byte_idx_d    = byte_idx_q;
    asm_d         = asm_q;
    timeout_err_d = 1'b0;

    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      byte_idx_d = '0;
      asm_d      = '0;
    end else if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      byte_idx_d = '0;
      asm_d      = '0;
    end else begin
      if (byte_acc) begin
        byte_idx_d = byte_idx_q + 1'b1;
        case (byte_idx_q)
          2'd0: asm_d[7:0]   = bus.byte_in;
          2'd1: asm_d[15:8]  = bus.byte_in;
          2'd2: asm_d[23:16] = bus.byte_in;
          default: begin
            mem_d[wr_ptr_q] = {bus.byte_in, asm_q};
            wr_ptr_d        = wr_ptr_q + 1'b1;
            asm_d           = '0;
          end
        endcase
      end else if (timeout_hit) begin
        byte_idx_d    = '0;
        asm_d         = '0;
        timeout_err_d = 1'b1;
      end

      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

      if (push && !pop) begin
        level_d = level_q + 1'b1;
      end else if (pop && !push) begin
        level_d = level_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    wr_ptr_q      <= wr_ptr_d;
    rd_ptr_q      <= rd_ptr_d;
    level_q       <= level_d;
    byte_idx_q    <= byte_idx_d;
    asm_q         <= asm_d;
    timeout_err_q <= timeout_err_d;
  end

endmodule

// File: tb/tb_instr_byte_feeder.sv
// Directed self-checking bench for instr_byte_feeder (DEPTH=4, TIMEOUT_CYCLES=8).
// Timeout expectations follow whether PARTIAL_WORD_TIMEOUT_EN is defined for the build.
module tb_instr_byte_feeder;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [2:0] level;
  logic [1:0] byte_idx;
  logic       timeout_err;
  int         errors;
  int         checks;
  int         pulses;

  instr_byte_feeder_if bus ();

  instr_byte_feeder #(.DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .bus         (bus),
    .level       (level),
    .byte_idx    (byte_idx),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drive one cycle of inputs, sample 1 ns after the edge, then release strobes
  task automatic applyStimulus(input logic fl, input logic v, input logic [7:0] b, input logic r);
    flush           = fl;
    bus.byte_valid  = v;
    bus.byte_in     = b;
    bus.instr_ready = r;
    @(posedge clk);
    #1;
    flush           = 1'b0;
    bus.byte_valid  = 1'b0;
    bus.instr_ready = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, w[8*i +: 8], 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    flush = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_in = 8'h00;
    bus.instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_byte_ready", {31'b0, bus.byte_ready}, 32'd0);
    checkOutput("rst_level", {29'b0, level}, 32'd0);
    checkOutput("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
    checkOutput("rst_instr", bus.instr, 32'd0);
    checkOutput("rst_idx", {30'b0, byte_idx}, 32'd0);
    checkOutput("rst_terr", {31'b0, timeout_err}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", {31'b0, bus.byte_ready}, 32'd1);

    sendWord(32'h00A00513);
    checkOutput("basic_instr", bus.instr, 32'h00A00513);
    checkOutput("basic_valid", {31'b0, bus.instr_valid}, 32'd1);
    checkOutput("basic_level", {29'b0, level}, 32'd1);
    checkOutput("basic_idx", {30'b0, byte_idx}, 32'd0);

    sendWord(32'h11223344);
    sendWord(32'h55667788);
    sendWord(32'h99AABBCC);
    checkOutput("fill_level", {29'b0, level}, 32'd4);
    checkOutput("fill_head", bus.instr, 32'h00A00513);
    applyStimulus(1'b0, 1'b1, 8'hEF, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hBE, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hAD, 1'b0);
    checkOutput("fill_idx3", {30'b0, byte_idx}, 32'd3);
    checkOutput("full_lane3_ready", {31'b0, bus.byte_ready}, 32'd0);
    applyStimulus(1'b0, 1'b1, 8'hDE, 1'b1);
    checkOutput("pop_full_level", {29'b0, level}, 32'd3);
    checkOutput("pop_full_idx", {30'b0, byte_idx}, 32'd3);
    checkOutput("pop_full_ready", {31'b0, bus.byte_ready}, 32'd1);
    checkOutput("pop_full_head", bus.instr, 32'h11223344);
    applyStimulus(1'b0, 1'b1, 8'hDE, 1'b0);
    checkOutput("refill_level", {29'b0, level}, 32'd4);
    checkOutput("refill_idx", {30'b0, byte_idx}, 32'd0);
    checkOutput("order_1", bus.instr, 32'h11223344);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("order_2", bus.instr, 32'h55667788);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("order_3", bus.instr, 32'h99AABBCC);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("order_4", bus.instr, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("drain_level", {29'b0, level}, 32'd0);
    checkOutput("drain_valid", {31'b0, bus.instr_valid}, 32'd0);

    sendWord(32'h01020304);
    sendWord(32'h0A0B0C0D);
    applyStimulus(1'b0, 1'b1, 8'h0D, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hF0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hFE, 1'b0);
    checkOutput("conc_old_head", bus.instr, 32'h01020304);
    applyStimulus(1'b0, 1'b1, 8'hCA, 1'b1);
    checkOutput("conc_level", {29'b0, level}, 32'd2);
    checkOutput("conc_head", bus.instr, 32'h0A0B0C0D);
    checkOutput("conc_idx", {30'b0, byte_idx}, 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("conc_tail", bus.instr, 32'hCAFEF00D);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    sendWord(32'h12345678);
    applyStimulus(1'b0, 1'b1, 8'hA1, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hA2, 1'b0);
    checkOutput("pre_flush_idx", {30'b0, byte_idx}, 32'd2);
    flush = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_in = 8'h55;
    #1;
    checkOutput("flush_ready", {31'b0, bus.byte_ready}, 32'd0);
    applyStimulus(1'b1, 1'b1, 8'h55, 1'b0);
    checkOutput("flush_idx", {30'b0, byte_idx}, 32'd0);
    checkOutput("flush_level", {29'b0, level}, 32'd0);
    checkOutput("flush_valid", {31'b0, bus.instr_valid}, 32'd0);

    sendWord(32'h10101010);
    sendWord(32'h20202020);
    sendWord(32'h30303030);
    applyStimulus(1'b0, 1'b1, 8'h77, 1'b0);
    checkOutput("pre_rst_level", {29'b0, level}, 32'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_level", {29'b0, level}, 32'd0);
    checkOutput("mid_rst_instr", bus.instr, 32'd0);
    checkOutput("mid_rst_ready", {31'b0, bus.byte_ready}, 32'd0);
    checkOutput("mid_rst_idx", {30'b0, byte_idx}, 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 8'h5A, 1'b0);
    checkOutput("post_rst_idx", {30'b0, byte_idx}, 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h6B, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h7C, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h8D, 1'b0);
    checkOutput("post_rst_word", bus.instr, 32'h8D7C6B5A);

    applyStimulus(1'b0, 1'b1, 8'h11, 1'b0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (timeout_err) pulses++;
    end
`ifdef PARTIAL_WORD_TIMEOUT_EN
    checkOutput("timeout_pulses", pulses, 32'd1);
    checkOutput("timeout_idx", {30'b0, byte_idx}, 32'd0);
`else
    checkOutput("timeout_pulses", pulses, 32'd0);
    checkOutput("timeout_idx", {30'b0, byte_idx}, 32'd1);
`endif
    checkOutput("timeout_level", {29'b0, level}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
